// File: rtl/dmem_responder.sv
// Data-memory target for core load/store traffic: one request at a time,
// word load or byte-masked store, response after LATENCY edges.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            lat_we;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_wdata;
    logic [3:0]      lat_be;
    logic [31:0]     mem [WORDS];

    logic [DEPTH_LOG2-1:0] idx;
    logic            misaligned;
    logic            out_of_range;
    logic            bad;
    logic            access;

    assign idx          = lat_addr[DEPTH_LOG2+1:2];
    assign misaligned   = lat_addr[1:0] != 2'b00;
    assign out_of_range = (lat_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
    assign bad          = misaligned | out_of_range;
    assign access       = (state == WAIT) && (cnt == 4'd0);
    assign req_ready    = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_be     <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        cnt       <= CNT_INIT;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= bad;
                        resp_rdata <= (bad || lat_we) ? 32'd0 : mem[idx];
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Kept apart from the control block so the array has no reset path.
    always_ff @(posedge clk) begin
        if (!reset && access && lat_we && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_be[b]) mem[idx][8*b +: 8] <= lat_wdata[8*b +: 8];
            end
        end
    end

`ifndef SYNTHESIS
    logic        prev_valid;
    logic        prev_ready;
    logic [31:0] prev_rdata;
    logic        prev_err;

    initial begin
        if (LATENCY < 1 || LATENCY > 15) begin
            $display("dmem_responder: ERROR LATENCY=%0d outside 1..15", LATENCY);
            $finish;
        end
        for (int i = 0; i < WORDS; i++) mem[i] = 32'd0;
    end

    always @(posedge clk) begin
        if (!reset && prev_valid && !prev_ready && resp_valid &&
            (resp_rdata !== prev_rdata || resp_err !== prev_err))
            $display("dmem_responder: ERROR response changed before handshake");
        prev_valid <= resp_valid && !reset;
        prev_ready <= resp_ready;
        prev_rdata <= resp_rdata;
        prev_err   <= resp_err;
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=1, one at LATENCY=4,
// directed cases followed by random traffic against a word-array model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_be     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    logic [31:0] mdl [2][256];
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(4)) u_lat4 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; expected response comes from the word model.
    task automatic xact(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int hold, input string tag);
        logic        exp_err;
        logic [31:0] exp_data;
        int          idx;
        int          k;
        exp_err  = (addr % 4 != 0) || (addr >= 32'h400);
        idx      = int'(addr[9:2]);
        exp_data = (exp_err || we) ? 32'd0 : mdl[d][idx];

        chk({tag, ":ready_before"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        tick();
        // Garbage on the request lines after acceptance must not matter.
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom);

        k = 0;
        while (!resp_valid[d] && k < 20) begin
            chk({tag, ":ready_wait"}, 32'(req_ready[d]), 32'd0);
            tick();
            k++;
        end
        chk({tag, ":latency"}, 32'(k), 32'(lat_of(d)));
        chk({tag, ":rdata"}, resp_rdata[d], exp_data);
        chk({tag, ":err"}, 32'(resp_err[d]), 32'(exp_err));

        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, ":hold_valid"}, 32'(resp_valid[d]), 32'd1);
            chk({tag, ":hold_rdata"}, resp_rdata[d], exp_data);
            chk({tag, ":hold_err"}, 32'(resp_err[d]), 32'(exp_err));
            chk({tag, ":hold_ready"}, 32'(req_ready[d]), 32'd0);
        end

        resp_ready[d] = 1'b1;
        tick();
        resp_ready[d] = 1'b0;
        chk({tag, ":valid_after"}, 32'(resp_valid[d]), 32'd0);
        chk({tag, ":ready_after"}, 32'(req_ready[d]), 32'd1);

        if (we && !exp_err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[d][idx][8*b +: 8] = wdata[8*b +: 8];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; req_be[d] = 4'd0;
            resp_ready[d] = 1'b0;
            for (int i = 0; i < 256; i++) mdl[d][i] = 32'd0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset_valid", 32'(resp_valid[d]), 32'd0);
            chk("reset_rdata", resp_rdata[d], 32'd0);
            chk("reset_err", 32'(resp_err[d]), 32'd0);
            chk("reset_ready", 32'(req_ready[d]), 32'd1);
            reset[d] = 1'b0;
        end
        tick();

        // Store then load, byte-masked store, error cases.
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st_10");
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, "ld_10");
        xact(0, 1'b1, 32'h14, 32'h11223344, 4'hF, 0, "st_14");
        xact(0, 1'b1, 32'h14, 32'hAABBCCDD, 4'h5, 1, "st_14_be5");
        xact(0, 1'b0, 32'h14, 32'h0, 4'h0, 0, "ld_14");
        xact(0, 1'b1, 32'h18, 32'hFFFFFFFF, 4'h0, 0, "st_be0");
        xact(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, "ld_misal");
        xact(0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0, "st_oor");
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, "ld_0");

        // Latency 4 with backpressure.
        xact(1, 1'b0, 32'h0, 32'h0, 4'h0, 3, "l4_ld_0");

        // Reset lands before the access edge: the store must be dropped.
        chk("rst_mid_ready", 32'(req_ready[1]), 32'd1);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
        req_wdata[1] = 32'h12345678; req_be[1] = 4'hF;
        tick();
        req_valid[1] = 1'b0;
        tick();
        chk("rst_mid_valid0", 32'(resp_valid[1]), 32'd0);
        reset[1] = 1'b1;
        tick();
        reset[1] = 1'b0;
        chk("rst_mid_valid1", 32'(resp_valid[1]), 32'd0);
        chk("rst_mid_ready_after", 32'(req_ready[1]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_mid_no_resp", 32'(resp_valid[1]), 32'd0);
        end
        xact(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, "rst_mid_ld_20");

        // Request held across reset must only be taken once reset drops.
        reset[0] = 1'b1;
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_samp_ready", 32'(req_ready[0]), 32'd1);
            chk("rst_samp_valid", 32'(resp_valid[0]), 32'd0);
        end
        reset[0] = 1'b0;
        tick();
        req_valid[0] = 1'b0;
        chk("rst_samp_accepted", 32'(req_ready[0]), 32'd0);
        tick();
        chk("rst_samp_resp", 32'(resp_valid[0]), 32'd1);
        chk("rst_samp_rdata", resp_rdata[0], mdl[0][4]);
        resp_ready[0] = 1'b1;
        tick();
        resp_ready[0] = 1'b0;
        chk("rst_samp_ready_after", 32'(req_ready[0]), 32'd1);

        // Random traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                case ($urandom_range(0, 9))
                    0: a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
                    1: a = $urandom | 32'h400;
                    default: a = 32'($urandom_range(0, 31)) << 2;
                endcase
                xact(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                     $urandom_range(0, 2), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store traffic: the target side of the core's data-memory accesses, replacing the core-internal behavioral array.
- Accepts one request at a time over a valid/ready request channel and performs a word read or a byte-masked write.
- Returns a response after a programmable latency over a valid/ready response channel.
- Flags misaligned and out-of-range addresses instead of accessing memory.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words (default 256 words = 1 KiB).
- LATENCY, 1, number of clock edges from request acceptance to response valid. Legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; bit n enables byte n, i.e. wdata[8n+7:8n]. Ignored for loads.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data; 0 for stores and for errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset is synchronous and active-high, sampled on posedge clk.
- Reset values:
  - state = IDLE.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Latency counter = 0.
  - Latched request fields = 0.
  - Memory contents are NOT cleared by reset; they are zero-initialized at simulation start only.
- req_ready:
  - Equals (state == IDLE), combinational from state.
  - A request presented while reset is high is not accepted.
- States:
  - IDLE:
    - Handshake occurs when req_valid && req_ready at a posedge.
    - On handshake, latch we, addr, wdata and be; load counter with LATENCY-1; go to WAIT.
  - WAIT:
    - Each posedge with counter != 0 decrements the counter.
    - At the posedge with counter == 0, perform the access, go to RESP and set resp_valid = 1.
  - RESP:
    - resp_valid, resp_rdata and resp_err are held stable until resp_ready is high at a posedge.
    - At that edge: resp_valid = 0 and state = IDLE.
    - No new request is accepted in the same edge. Maximum throughput is one request per LATENCY+2 cycles.
- Timing: resp_valid rises exactly LATENCY posedges after the acceptance edge.
- Error check, evaluated on the latched address at access time:
  - misaligned = addr[1:0] != 0.
  - out of range = addr[31:DEPTH_LOG2+2] != 0.
  - On error: no memory read or write, resp_err = 1, resp_rdata = 0.
- Access:
  - Word index = addr[DEPTH_LOG2+1:2].
  - Load: resp_rdata = mem[index], full word, be ignored.
  - Store: each enabled byte is written; disabled bytes are unchanged; resp_rdata = 0.
  - Store with be = 0 is legal: no change, resp_err = 0.
- Ordering: a load issued after a store completes returns the stored data, since there is only one request outstanding.
- Input handling: requester changes on req_* while the responder is in WAIT or RESP have no effect, because the request was latched at acceptance.
- Reset mid-operation: reset in WAIT or RESP aborts the transaction.
  - No write is performed if the access edge has not yet occurred.
  - resp_valid drops to 0 at the reset edge.
  - The responder is in IDLE with req_ready = 1 in the cycle after reset deasserts.
- Simulation-only checks:
  - Protocol violation: $display an error if resp_valid is high and resp_rdata or resp_err changes before the handshake.
  - Parameter check: $display an error and $finish if LATENCY is outside 1..15.

Test Plan:
1. Store then load (LATENCY=1):
   - Store addr 0x10, wdata 0xDEADBEEF, be 0xF; then load addr 0x10.
   - Required: store response with err=0, rdata=0; load returns 0xDEADBEEF.
   - Required: each resp_valid rises exactly 1 edge after acceptance.
2. Byte-masked store:
   - mem[5] = 0x11223344; store addr 0x14, wdata 0xAABBCCDD, be 0x5.
   - Required: a later load of 0x14 returns 0x11BB33DD.
3. Errors (DEPTH_LOG2=8):
   - Load addr 0x13 -> resp_err=1, rdata=0.
   - Store to addr 0x400 -> resp_err=1, and mem[0] is unchanged on a later read.
4. Latency and backpressure (LATENCY=4):
   - Load addr 0x0; hold resp_ready=0 for 3 cycles.
   - Required: resp_valid rises 4 edges after acceptance; rdata and err stay stable; req_ready=0 throughout.
   - Required: req_ready=1 the cycle after the resp handshake.
5. Reset mid-operation (LATENCY=4):
   - Store addr 0x20, wdata 0x12345678; assert reset 2 edges after acceptance.
   - Required: resp_valid never rises; a later load of 0x20 returns the old value 0x0.
   - Required: req_ready=1 the cycle after reset deasserts.
6. Reset sampling:
   - Hold req_valid=1 during reset.
   - Required: no acceptance while reset is high; acceptance occurs on the first edge after reset drops.
